imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH_LOG2, default 8, memory holds 2**DEPTH_LOG2 32-bit words.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ld_valid  in  1  load byte present this cycle; accepted unconditionally.
REQ-005 ld_data  in  8  load byte.
REQ-006 ld_done  in  1  single-cycle pulse, ends the current program load.
REQ-007 instr_addr  in  32  word address requested by the core (pc_next).
REQ-008 instr_data  out  32  registered instruction word for the previous cycle's instr_addr.
REQ-009 last_pc  out  32  word index of the last loaded instruction.
REQ-010 core_rst  out  1  high while no valid program is present; holds the core in reset.
REQ-011 overflow  out  1  sticky; load exceeded memory depth.

Function
REQ-012 The block SHALL implement states EMPTY, LOAD and RUN.
REQ-013 Transitions: EMPTY/RUN -> LOAD on ld_valid; LOAD -> RUN on ld_done with at least one word stored; LOAD -> EMPTY on ld_done with zero words stored; ld_done outside LOAD SHALL be ignored.
REQ-014 Entry into LOAD SHALL clear the word counter, byte counter and overflow, and SHALL accept that cycle's byte as byte 0.
REQ-015 Bytes SHALL be packed little-endian: byte n of a word goes to bits [8n+7:8n].
REQ-016 On the 4th byte, the assembled word SHALL be written to mem[word_cnt] in the same cycle, and word_cnt incremented.
REQ-017 When word_cnt equals 2**DEPTH_LOG2, further bytes SHALL be dropped and overflow set; word_cnt SHALL NOT wrap.
REQ-018 On ld_done with 1-3 pending bytes, the partial word SHALL be zero-padded in the upper bytes and written as one word (unless full).
REQ-019 ld_valid and ld_done in the same cycle: the byte SHALL be taken first, then the load ended including that byte.
REQ-020 On LOAD -> RUN, last_pc SHALL become word_cnt-1 (final count incl. any padded word) in the same edge.
REQ-021 core_rst SHALL be 1 in EMPTY and LOAD and 0 in RUN, registered (low from the first cycle in RUN).
REQ-022 In RUN, instr_data SHALL equal mem[instr_addr[DEPTH_LOG2-1:0]] one cycle after instr_addr is presented (1-cycle latency, every cycle, no stall).
REQ-023 In EMPTY and LOAD, instr_data SHALL be 32'h00000013 (NOP).
REQ-024 A new ld_valid in RUN SHALL restart loading (REQ-014), asserting core_rst from the next cycle.

Reset
REQ-025 On rst: state EMPTY, word_cnt 0, byte_cnt 0, instr_data 32'h00000013, last_pc 0, core_rst 1, overflow 0.
REQ-026 rst during LOAD SHALL discard the partial load; memory contents after reset are unspecified and never read until a new load completes.
REQ-027 rst SHALL have priority over ld_valid and ld_done in the same cycle.

Configuration
REQ-028 Macro IMEM_BOUNDS_CHECK_EN compiled in: in RUN, an instr_addr greater than last_pc (unsigned, full 32 bits) SHALL return 32'h00000013.
REQ-029 Without IMEM_BOUNDS_CHECK_EN: address truncated to DEPTH_LOG2 bits, aliasing permitted, no comparison logic.

Verification
REQ-030 Reset, then 8 bytes 13,05,10,00,93,05,20,00 then ld_done -> mem[0]=00100513, mem[1]=00200593, last_pc=1, core_rst 0 one cycle after ld_done edge.
REQ-031 RUN, instr_addr=1 at cycle N -> instr_data=00200593 at cycle N+1; instr_addr=0 at N+1 -> 00100513 at N+2.
REQ-032 5 bytes AA,BB,CC,DD,EE with ld_done on the byte EE -> mem[1]=000000EE, last_pc=1.
REQ-033 DEPTH_LOG2=2, 20 bytes loaded -> overflow=1, last_pc=3, bytes 17-20 not written; rst clears overflow.
REQ-034 rst asserted after 3 bytes -> state EMPTY, core_rst 1, instr_data 00000013; ld_done alone afterwards -> no change.
REQ-035 With IMEM_BOUNDS_CHECK_EN, last_pc=1, instr_addr=2 -> instr_data 00000013; without it, instr_addr=2 -> mem[2] contents.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader -- byte-stream program loader and instruction memory.
//
// A host streams a program in as bytes (little-endian words). While loading,
// the attached core is held in reset; once a load completes with at least one
// word, the core is released and fetches from the memory with a fixed
// one-cycle read latency.
//
// Ports:
//   clk         single clock, all state on posedge
//   rst         synchronous active-high reset
//   ld_valid    load byte present this cycle (always accepted)
//   ld_data     load byte
//   ld_done     one-cycle pulse ending the current load
//   instr_addr  word address from the core (pc_next)
//   instr_data  registered instruction word for the previous instr_addr
//   last_pc     word index of the last loaded instruction
//   core_rst    high while no valid program is present
//   overflow    sticky, load exceeded memory depth
//
// Handshake: the load port has no back-pressure. A byte is consumed on every
// cycle ld_valid is high; ld_done is only meaningful in LOAD, or in the same
// cycle as the byte that starts a load.
//
// Optional feature macro: IMEM_BOUNDS_CHECK_EN -- in RUN, fetches above
// last_pc (full 32-bit unsigned compare) return NOP instead of aliasing.
//
// Debug: the FSM state is the enum register `state`.

module imem_loader #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_done,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic [31:0] last_pc,
    output logic        core_rst,
    output logic        overflow
);

    localparam int          DEPTH = 2 ** DEPTH_LOG2;
    localparam int          CW    = DEPTH_LOG2 + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   word_cnt, word_nxt, w_base;
    logic [1:0]      byte_cnt, byte_nxt, b_base;
    logic [23:0]     pend, pend_nxt, p_base;
    logic            ovf_nxt, o_base;
    logic [31:0]     last_nxt;
    logic            start, in_load;
    logic            wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [31:0]     wr_data;
    logic [31:0]     rd_word;
    logic [31:0]     mem [DEPTH];

    // The upper address bits only matter when the bounds check is built in.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^instr_addr[31:DEPTH_LOG2];

    always_comb begin
        // A byte outside LOAD starts a fresh load: counters restart from zero
        // and that same byte becomes byte 0.
        start     = (state != LOAD) && ld_valid;
        in_load   = (state == LOAD) || start;
        w_base    = start ? '0 : word_cnt;
        b_base    = start ? '0 : byte_cnt;
        p_base    = start ? '0 : pend;
        o_base    = start ? 1'b0 : overflow;

        state_nxt = state;
        word_nxt  = w_base;
        byte_nxt  = b_base;
        pend_nxt  = p_base;
        ovf_nxt   = o_base;
        last_nxt  = last_pc;
        wr_en     = 1'b0;
        wr_addr   = w_base[DEPTH_LOG2-1:0];
        wr_data   = '0;

        if (in_load) begin
            state_nxt = LOAD;
            if (ld_valid) begin
                if (w_base[DEPTH_LOG2]) begin
                    // Memory full: drop the byte, word_cnt stays saturated.
                    ovf_nxt = 1'b1;
                end else if (b_base == 2'd3) begin
                    wr_en    = 1'b1;
                    wr_addr  = w_base[DEPTH_LOG2-1:0];
                    wr_data  = {ld_data, p_base};
                    word_nxt = w_base + 1'b1;
                    byte_nxt = '0;
                    pend_nxt = '0;
                end else begin
                    pend_nxt = p_base | ({16'h0000, ld_data} << {b_base, 3'b000});
                    byte_nxt = b_base + 2'd1;
                end
            end
            // Done is evaluated after this cycle's byte, so a byte arriving
            // with ld_done is part of the finished program. The two write
            // cases are exclusive: a pending partial word implies no full
            // word was written this cycle.
            if (ld_done) begin
                if ((byte_nxt != 2'd0) && !word_nxt[DEPTH_LOG2]) begin
                    wr_en    = 1'b1;
                    wr_addr  = word_nxt[DEPTH_LOG2-1:0];
                    wr_data  = {8'h00, pend_nxt};
                    word_nxt = word_nxt + 1'b1;
                end
                byte_nxt = '0;
                pend_nxt = '0;
                if (word_nxt == '0) begin
                    state_nxt = EMPTY;
                end else begin
                    state_nxt = RUN;
                    last_nxt  = 32'(word_nxt) - 32'd1;
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[instr_addr[DEPTH_LOG2-1:0]];
`ifdef IMEM_BOUNDS_CHECK_EN
        if (instr_addr > last_pc) begin
            rd_word = NOP;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            pend       <= '0;
            overflow   <= 1'b0;
            last_pc    <= '0;
            core_rst   <= 1'b1;
            instr_data <= NOP;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_nxt;
            byte_cnt <= byte_nxt;
            pend     <= pend_nxt;
            overflow <= ovf_nxt;
            last_pc  <= last_nxt;
            core_rst <= (state_nxt != RUN);
            // Fetch only from a stable program; a byte arriving in RUN starts
            // a reload, so the core sees NOP from then on.
            if ((state == RUN) && !ld_valid) begin
                instr_data <= rd_word;
            end else begin
                instr_data <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Two instances share all stimulus: a default
// depth instance (256 words) and a 4-word instance for overflow/aliasing.

module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_done;
    logic [31:0] instr_addr;
    logic [31:0] instr_data, s_instr_data;
    logic [31:0] last_pc, s_last_pc;
    logic        core_rst, s_core_rst;
    logic        overflow, s_overflow;

    int total = 0;
    int bad   = 0;

    imem_loader #(.DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_done(ld_done), .instr_addr(instr_addr), .instr_data(instr_data),
        .last_pc(last_pc), .core_rst(core_rst), .overflow(overflow)
    );

    imem_loader #(.DEPTH_LOG2(2)) dut_s (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_done(ld_done), .instr_addr(instr_addr), .instr_data(s_instr_data),
        .last_pc(s_last_pc), .core_rst(s_core_rst), .overflow(s_overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change and outputs are sampled 1 time unit after posedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic done);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_done  = done;
        tick();
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b0);
        end
    endtask

    task automatic pulse_done();
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        instr_addr = a;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (instr_data !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h exp=%h", instr_data, 32'h13); end
        total++; if (last_pc !== 32'd0) begin bad++; $display("FAIL rst_last_pc got=%h exp=0", last_pc); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL rst_core_rst got=%b exp=1", core_rst); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_load_basic();
        send_byte(8'h13, 1'b0);
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL load_core_rst got=%b exp=1", core_rst); end
        send_byte(8'h05, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
        total++; if (instr_data !== 32'h13) begin bad++; $display("FAIL load_nop got=%h exp=%h", instr_data, 32'h13); end
        pulse_done();
        total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL basic_core_rst got=%b exp=0", core_rst); end
        total++; if (last_pc !== 32'd1) begin bad++; $display("FAIL basic_last_pc got=%h exp=1", last_pc); end
        total++; if (s_last_pc !== 32'd1) begin bad++; $display("FAIL basic_s_last_pc got=%h exp=1", s_last_pc); end
        fetch(32'd1);
        total++; if (instr_data !== 32'h00200593) begin bad++; $display("FAIL read1 got=%h exp=00200593", instr_data); end
        fetch(32'd0);
        total++; if (instr_data !== 32'h00100513) begin bad++; $display("FAIL read0 got=%h exp=00100513", instr_data); end
        total++; if (s_instr_data !== 32'h00100513) begin bad++; $display("FAIL s_read0 got=%h exp=00100513", s_instr_data); end
    endtask

    task automatic test_partial();
        // reload from RUN: core goes back into reset immediately
        send_byte(8'hAA, 1'b0);
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reload_core_rst got=%b exp=1", core_rst); end
        total++; if (instr_data !== 32'h13) begin bad++; $display("FAIL reload_nop got=%h exp=%h", instr_data, 32'h13); end
        send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b1);
        total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL partial_core_rst got=%b exp=0", core_rst); end
        total++; if (last_pc !== 32'd1) begin bad++; $display("FAIL partial_last_pc got=%h exp=1", last_pc); end
        fetch(32'd1);
        total++; if (instr_data !== 32'h000000EE) begin bad++; $display("FAIL partial_pad got=%h exp=000000ee", instr_data); end
        fetch(32'd0);
        total++; if (instr_data !== 32'hDDCCBBAA) begin bad++; $display("FAIL partial_w0 got=%h exp=ddccbbaa", instr_data); end
    endtask

    task automatic test_bounds();
        logic [31:0] exp2, exp5;
        send_word(32'h11111111); send_word(32'h22222222); send_word(32'h33333333);
        pulse_done();
        total++; if (last_pc !== 32'd2) begin bad++; $display("FAIL bounds_last_pc3 got=%h exp=2", last_pc); end
        send_word(32'hCAFE0001); send_word(32'hCAFE0002);
        pulse_done();
        total++; if (last_pc !== 32'd1) begin bad++; $display("FAIL bounds_last_pc2 got=%h exp=1", last_pc); end
`ifdef IMEM_BOUNDS_CHECK_EN
        exp2 = 32'h13;
        exp5 = 32'h13;
`else
        exp2 = 32'h33333333;
        exp5 = 32'hCAFE0002;
`endif
        fetch(32'd2);
        total++; if (instr_data !== exp2) begin bad++; $display("FAIL bounds_addr2 got=%h exp=%h", instr_data, exp2); end
        total++; if (s_instr_data !== exp2) begin bad++; $display("FAIL s_bounds_addr2 got=%h exp=%h", s_instr_data, exp2); end
        fetch(32'd5);
        total++; if (s_instr_data !== exp5) begin bad++; $display("FAIL s_alias_addr5 got=%h exp=%h", s_instr_data, exp5); end
        fetch(32'd1);
        total++; if (instr_data !== 32'hCAFE0002) begin bad++; $display("FAIL bounds_addr1 got=%h exp=cafe0002", instr_data); end
        instr_addr = 32'd0;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 20; i++) begin
            send_byte(8'(i), 1'b0);
        end
        total++; if (s_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", s_overflow); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_big got=%b exp=0", overflow); end
        pulse_done();
        total++; if (s_last_pc !== 32'd3) begin bad++; $display("FAIL ovf_last_pc got=%h exp=3", s_last_pc); end
        total++; if (last_pc !== 32'd4) begin bad++; $display("FAIL big_last_pc got=%h exp=4", last_pc); end
        total++; if (s_core_rst !== 1'b0) begin bad++; $display("FAIL ovf_core_rst got=%b exp=0", s_core_rst); end
        fetch(32'd0);
        total++; if (s_instr_data !== 32'h04030201) begin bad++; $display("FAIL ovf_no_wrap got=%h exp=04030201", s_instr_data); end
        fetch(32'd3);
        total++; if (s_instr_data !== 32'h100F0E0D) begin bad++; $display("FAIL ovf_w3 got=%h exp=100f0e0d", s_instr_data); end
        fetch(32'd4);
        total++; if (instr_data !== 32'h14131211) begin bad++; $display("FAIL big_w4 got=%h exp=14131211", instr_data); end
        instr_addr = 32'd0;
        total++; if (s_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", s_overflow); end
        do_reset();
        total++; if (s_overflow !== 1'b0) begin bad++; $display("FAIL ovf_rst got=%b exp=0", s_overflow); end
        total++; if (s_instr_data !== 32'h13) begin bad++; $display("FAIL ovf_rst_nop got=%h exp=%h", s_instr_data, 32'h13); end
    endtask

    task automatic test_reset_mid_load();
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        do_reset();
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL midrst_core_rst got=%b exp=1", core_rst); end
        total++; if (instr_data !== 32'h13) begin bad++; $display("FAIL midrst_nop got=%h exp=%h", instr_data, 32'h13); end
        pulse_done();
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL done_ignored got=%b exp=1", core_rst); end
        total++; if (last_pc !== 32'd0) begin bad++; $display("FAIL done_ignored_pc got=%h exp=0", last_pc); end
        // reset wins over a byte in the same cycle
        rst = 1'b1; ld_valid = 1'b1; ld_data = 8'h77;
        tick();
        rst = 1'b0; ld_valid = 1'b0;
        pulse_done();
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL rst_priority got=%b exp=1", core_rst); end
    endtask

    task automatic test_back_to_back();
        // a single byte with ld_done from EMPTY forms a one-word program
        send_byte(8'h55, 1'b1);
        total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL b2b_core_rst got=%b exp=0", core_rst); end
        total++; if (last_pc !== 32'd0) begin bad++; $display("FAIL b2b_last_pc got=%h exp=0", last_pc); end
        fetch(32'd0);
        total++; if (instr_data !== 32'h00000055) begin bad++; $display("FAIL b2b_word got=%h exp=00000055", instr_data); end
    endtask

    initial begin
        rst = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_done = 1'b0; instr_addr = 32'd0;
        tick();
        test_reset();
        test_load_basic();
        test_partial();
        test_bounds();
        test_overflow();
        test_reset_mid_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
